// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage MIPS pipeline.
//
// Owns the PC and fetches from a variable-latency instruction memory over a
// req/ack handshake. It holds its outputs on hazard stalls and redirects on
// branches and jumps. When no instruction is ready it emits a NOP bubble. In the
// cycle after a redirect is sampled it pulses Flush_Ctrl so IF/ID drops the
// wrong-path slot.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stall                      hazard hold of IF outputs and PC
//   branch_taken/branch_target branch redirect (wins over jump)
//   jump/jump_target           jump redirect
//   imem_req/imem_addr         fetch request and address
//   imem_ack/imem_rdata        read data valid / instruction word
//   PC_out, instr_out          PC+4 and instruction word to IF/ID
//   fetch_valid                instr_out is a real fetched instruction
//   Flush_Ctrl                 one-cycle flush pulse to IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instr_out,
  output logic        fetch_valid,
  output logic        Flush_Ctrl
);

  typedef enum logic [1:0] {StFetch, StFull, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] buf_q;
  logic [31:0] buf_pc_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = branch_taken | jump;
    target   = (branch_taken ? branch_target : jump_target) & ~32'h0000_0003;
    pc_plus4 = pc_q + 32'd4;
  end

  // Both are simple selects of registered state.
  always_comb begin
    imem_req  = (state_q != StFull);
    imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_q        <= 32'h0;
      buf_pc_q     <= 32'h0;
      PC_out       <= 32'h0;
      instr_out    <= NOP_INSTR;
      fetch_valid  <= 1'b0;
      Flush_Ctrl   <= 1'b0;
    end else begin
      Flush_Ctrl <= redirect;
      unique case (state_q)
        StFetch: begin
          if (redirect) begin
            pc_q        <= target;
            PC_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            fetch_valid <= 1'b0;
            // An outstanding request must still complete; park its address.
            if (!imem_ack) begin
              drain_addr_q <= pc_q;
              state_q      <= StDrain;
            end
          end else if (imem_ack && !stall) begin
            instr_out   <= imem_rdata;
            PC_out      <= pc_plus4;
            fetch_valid <= 1'b1;
            pc_q        <= pc_plus4;
          end else if (imem_ack) begin
            // Stalled: catch the word in the skid buffer, outputs hold.
            buf_q    <= imem_rdata;
            buf_pc_q <= pc_plus4;
            pc_q     <= pc_plus4;
            state_q  <= StFull;
          end else if (!stall) begin
            PC_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            fetch_valid <= 1'b0;
          end
        end
        StFull: begin
          if (redirect) begin
            pc_q        <= target;
            PC_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            fetch_valid <= 1'b0;
            state_q     <= StFetch;
          end else if (!stall) begin
            instr_out   <= buf_q;
            PC_out      <= buf_pc_q;
            fetch_valid <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StDrain: begin
          PC_out      <= 32'h0;
          instr_out   <= NOP_INSTR;
          fetch_valid <= 1'b0;
          if (redirect) pc_q <= target;
          if (imem_ack) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        fetch_valid;
  logic        flush_ctrl;

  // tie=1 models a zero-wait memory (ack follows req, data derived from address).
  logic        tie;
  logic        ack_drv;
  logic [31:0] rdata_drv;

  int n_pass = 0;
  int n_total = 0;

  assign imem_ack   = tie ? imem_req : ack_drv;
  assign imem_rdata = tie ? (imem_addr ^ 32'hA5A5_0000) : rdata_drv;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PC_out        (pc_out),
    .instr_out     (instr_out),
    .fetch_valid   (fetch_valid),
    .Flush_Ctrl    (flush_ctrl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_instr"}, instr_out, 32'h0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_fv"}, {31'h0, fetch_valid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; tie = 1'b0; ack_drv = 1'b0; rdata_drv = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    step();
    step();
    chk_bubble("rst");
    chk("rst_flush", {31'h0, flush_ctrl}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0000_3000);

    // Zero-wait memory.
    rst_n = 1'b1; tie = 1'b1;
    step();
    chk("zw_addr1", imem_addr, 32'h0000_3004);
    chk("zw_pc1", pc_out, 32'h0000_3004);
    chk("zw_instr1", instr_out, 32'hA5A5_3000);
    chk("zw_fv1", {31'h0, fetch_valid}, 32'h1);

    // Two-cycle latency for 0x3004.
    tie = 1'b0; ack_drv = 1'b0;
    step();
    chk_bubble("lat_wait");
    chk("lat_addr_hold", imem_addr, 32'h0000_3004);
    chk("lat_req", {31'h0, imem_req}, 32'h1);
    ack_drv = 1'b1; rdata_drv = 32'h8C01_0004;
    step();
    chk("lat_instr", instr_out, 32'h8C01_0004);
    chk("lat_pc", pc_out, 32'h0000_3008);
    chk("lat_fv", {31'h0, fetch_valid}, 32'h1);
    chk("lat_addr_next", imem_addr, 32'h0000_3008);
    ack_drv = 1'b0;
    step();
    chk("lat2_addr", imem_addr, 32'h0000_3008);

    // Ack of 0x3008 under stall goes to the skid buffer.
    ack_drv = 1'b1; rdata_drv = 32'h2408_0005; stall = 1'b1;
    step();
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk_bubble("full_hold");
    ack_drv = 1'b0;
    step();
    chk("full2_req", {31'h0, imem_req}, 32'h0);
    chk("full2_fv", {31'h0, fetch_valid}, 32'h0);
    stall = 1'b0;
    step();
    chk("rel_instr", instr_out, 32'h2408_0005);
    chk("rel_pc", pc_out, 32'h0000_300C);
    chk("rel_fv", {31'h0, fetch_valid}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0000_300C);

    // Branch to unaligned 0x3043 while 0x300C is pending.
    branch_taken = 1'b1; branch_target = 32'h0000_3043;
    step();
    chk("br_flush", {31'h0, flush_ctrl}, 32'h1);
    chk("br_drain_addr", imem_addr, 32'h0000_300C);
    chk("br_req", {31'h0, imem_req}, 32'h1);
    chk_bubble("br");
    branch_taken = 1'b0;
    step();
    chk("br_flush_off", {31'h0, flush_ctrl}, 32'h0);
    chk("br_drain_hold", imem_addr, 32'h0000_300C);
    ack_drv = 1'b1; rdata_drv = 32'hDEAD_BEEF;
    step();
    chk("drop_addr", imem_addr, 32'h0000_3040);
    chk_bubble("drop");

    // Branch and jump together under stall: branch wins, stall ignored.
    ack_drv = 1'b0; stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_3100;
    jump = 1'b1; jump_target = 32'h0000_3200;
    step();
    chk("bj_flush", {31'h0, flush_ctrl}, 32'h1);
    chk("bj_drain_addr", imem_addr, 32'h0000_3040);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    ack_drv = 1'b1; rdata_drv = 32'h1234_5678;
    step();
    chk("bj_addr", imem_addr, 32'h0000_3100);
    chk("bj_flush_off", {31'h0, flush_ctrl}, 32'h0);
    chk_bubble("bj");

    // Back-to-back redirects into DRAIN, then reset with an ack in flight.
    ack_drv = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_3200;
    step();
    chk("b2b_addr", imem_addr, 32'h0000_3100);
    branch_target = 32'h0000_3300;
    step();
    chk("b2b_flush", {31'h0, flush_ctrl}, 32'h1);
    chk("b2b_addr2", imem_addr, 32'h0000_3100);
    branch_taken = 1'b0; rst_n = 1'b0; ack_drv = 1'b1; rdata_drv = 32'h1111_2222;
    step();
    chk_bubble("mrst");
    chk("mrst_flush", {31'h0, flush_ctrl}, 32'h0);
    chk("mrst_addr", imem_addr, 32'h0000_3000);
    chk("mrst_req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b1; ack_drv = 1'b0;
    step();
    chk("post_rst_addr", imem_addr, 32'h0000_3000);
    chk_bubble("post_rst");

    // Jump with simultaneous ack: data discarded, stay in FETCH; then PC wraps.
    jump = 1'b1; jump_target = 32'hFFFF_FFFF; ack_drv = 1'b1; rdata_drv = 32'h0000_5555;
    step();
    chk("jw_addr", imem_addr, 32'hFFFF_FFFC);
    chk("jw_flush", {31'h0, flush_ctrl}, 32'h1);
    chk_bubble("jw");
    jump = 1'b0; rdata_drv = 32'h3C01_1234;
    step();
    chk("wrap_instr", instr_out, 32'h3C01_1234);
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_fv", {31'h0, fetch_valid}, 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
